// File: rtl/control_unit_fft_iter_param.sv
// rtl/control_unit_fft_iter_param.sv - layer/butterfly sequencer for the iterative radix-2 FFT core
// Optional macro FFT_CTRL_RUNTIME_N_EN adds a runtime transform-size input N_LOG2.
module control_unit_fft_iter_param #(
    parameter int LOG2N   = 5,
    parameter int RD_LAT  = 1,
    parameter int BUT_LAT = 2,
    localparam int ButtWL = LOG2N - 1,
    localparam int LayWL  = $clog2(LOG2N + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              START,
`ifdef FFT_CTRL_RUNTIME_N_EN
    input  logic [LayWL-1:0]  N_LOG2,
`endif
    output logic              BUT_STROB,
    output logic              ADDR_EN,
    output logic              Wr,
    output logic              LAY_EN,
    output logic              FIRST,
    output logic              LAST,
    output logic              BUSY,
    output logic              DONE,
    output logic [LayWL-1:0]  LAY_CNT,
    output logic [ButtWL-1:0] BUT_CNT
);

    localparam int WaitMax = (RD_LAT > BUT_LAT) ? RD_LAT : BUT_LAT;
    localparam int WaitWL  = (WaitMax > 1) ? $clog2(WaitMax) : 1;
    localparam logic [WaitWL-1:0] RdLast  = WaitWL'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [WaitWL-1:0] ButLast = WaitWL'((BUT_LAT > 0) ? BUT_LAT - 1 : 0);
    localparam logic [LayWL-1:0]  LayMax  = LayWL'(LOG2N);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT_RD, S_STROB, S_WAIT_BUT, S_WRITE, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WaitWL-1:0]   r_wait;
    logic [LayWL-1:0]    r_lay;
    logic [ButtWL-1:0]   r_but;
    logic [LayWL-1:0]    w_layers;
    logic [ButtWL-1:0]   w_but_max;
    logic                w_lay_end;
    logic                w_final;

`ifdef FFT_CTRL_RUNTIME_N_EN
    logic [LayWL-1:0] r_nlog2;
    logic [LayWL-1:0] w_n_clamped;

    assign w_n_clamped = (N_LOG2 < LayWL'(2) || N_LOG2 > LayMax) ? LayMax : N_LOG2;

    // Size is captured only when a transform is accepted, so later N_LOG2 edits are ignored.
    always_ff @(posedge CLK) begin
        if (RST)
            r_nlog2 <= LayMax;
        else if (EN && r_state == S_IDLE && START)
            r_nlog2 <= w_n_clamped;
    end

    assign w_layers = r_nlog2;
`else
    assign w_layers = LayMax;
`endif

    // 2^(L-1)-1 as an all-ones field trimmed by the unused layers.
    assign w_but_max = {ButtWL{1'b1}} >> (LayMax - w_layers);
    assign w_lay_end = (r_but == w_but_max);
    assign w_final   = w_lay_end && (r_lay == w_layers - LayWL'(1));

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= S_IDLE;
        else if (EN)
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (START) w_next = S_READ;
            S_READ:     w_next = (RD_LAT == 0) ? S_STROB : S_WAIT_RD;
            S_WAIT_RD:  if (r_wait == RdLast) w_next = S_STROB;
            S_STROB:    w_next = (BUT_LAT == 0) ? S_WRITE : S_WAIT_BUT;
            S_WAIT_BUT: if (r_wait == ButLast) w_next = S_WRITE;
            S_WRITE:    w_next = w_final ? S_DONE : S_READ;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_wait <= '0;
        else if (EN)
            r_wait <= (w_next == r_state) ? r_wait + 1'b1 : '0;
    end

    // After the final write LAY_CNT steps to L, so neither FIRST nor LAST shows in DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lay <= '0;
            r_but <= '0;
        end else if (EN) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_lay <= '0;
                    r_but <= '0;
                end
                S_WRITE: begin
                    if (w_lay_end) begin
                        r_but <= '0;
                        r_lay <= r_lay + LayWL'(1);
                    end else begin
                        r_but <= r_but + ButtWL'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        BUT_STROB = (r_state == S_STROB);
        Wr        = (r_state == S_WRITE);
        ADDR_EN   = (r_state == S_WRITE);
        LAY_EN    = (r_state == S_WRITE) && w_lay_end;
        BUSY      = (r_state != S_IDLE);
        DONE      = (r_state == S_DONE);
        FIRST     = (r_state != S_IDLE) && (r_lay == '0);
        LAST      = (r_state != S_IDLE) && (r_lay == w_layers - LayWL'(1));
        LAY_CNT   = r_lay;
        BUT_CNT   = r_but;
    end

endmodule

// File: tb/tb_control_unit_fft_iter_param.sv
// tb/tb_control_unit_fft_iter_param.sv - self-checking bench for control_unit_fft_iter_param
module tb_control_unit_fft_iter_param;

    localparam int LOG2N  = 3;
    localparam int LayWL  = 2;
    localparam int ButtWL = 2;
    localparam int OW     = 8 + LayWL + ButtWL;

    logic CLK = 1'b0;
    logic RST, EN, START;
`ifdef FFT_CTRL_RUNTIME_N_EN
    logic [LayWL-1:0] n_log2;
`endif

    logic a_strob, a_aen, a_wr, a_layen, a_first, a_last, a_busy, a_done;
    logic b_strob, b_aen, b_wr, b_layen, b_first, b_last, b_busy, b_done;
    logic [LayWL-1:0]  a_lay, b_lay;
    logic [ButtWL-1:0] a_but, b_but;
    logic [OW-1:0]     got_a, got_b;

    always #5 CLK = ~CLK;

    control_unit_fft_iter_param #(.LOG2N(LOG2N), .RD_LAT(1), .BUT_LAT(2)) u_dut_a (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START),
`ifdef FFT_CTRL_RUNTIME_N_EN
        .N_LOG2(n_log2),
`endif
        .BUT_STROB(a_strob), .ADDR_EN(a_aen), .Wr(a_wr), .LAY_EN(a_layen),
        .FIRST(a_first), .LAST(a_last), .BUSY(a_busy), .DONE(a_done),
        .LAY_CNT(a_lay), .BUT_CNT(a_but)
    );

    control_unit_fft_iter_param #(.LOG2N(LOG2N), .RD_LAT(0), .BUT_LAT(0)) u_dut_b (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START),
`ifdef FFT_CTRL_RUNTIME_N_EN
        .N_LOG2(n_log2),
`endif
        .BUT_STROB(b_strob), .ADDR_EN(b_aen), .Wr(b_wr), .LAY_EN(b_layen),
        .FIRST(b_first), .LAST(b_last), .BUSY(b_busy), .DONE(b_done),
        .LAY_CNT(b_lay), .BUT_CNT(b_but)
    );

    always_comb begin
        got_a = {a_strob, a_aen, a_wr, a_layen, a_first, a_last, a_busy, a_done, a_lay, a_but};
        got_b = {b_strob, b_aen, b_wr, b_layen, b_first, b_last, b_busy, b_done, b_lay, b_but};
    end

    int checks = 0;
    int failures = 0;

    // Model: each instance is either idle or at cycle t (1-based) of its transform.
    int rdl[2] = '{1, 0};
    int btl[2] = '{2, 0};
    bit m_act[2];
    int m_t[2];
    int m_L[2];
    int start_edge[2];
    int edge_no = 0;

    function automatic int clamp_n(int v);
`ifdef FFT_CTRL_RUNTIME_N_EN
        return (v < 2 || v > LOG2N) ? LOG2N : v;
`else
        return LOG2N + 0 * v;
`endif
    endfunction

    function automatic int model_tdone(int i);
        int p, nb;
        p  = 3 + rdl[i] + btl[i];
        nb = 1 << (m_L[i] - 1);
        return m_L[i] * nb * p + 1;
    endfunction

    function automatic logic [OW-1:0] exp_out(int i);
        int p, nb, b, ph, lay, bc;
        bit wr;
        if (!m_act[i]) return '0;
        if (m_t[i] == model_tdone(i))
            return {6'b000000, 1'b1, 1'b1, LayWL'(m_L[i]), ButtWL'(0)};
        p   = 3 + rdl[i] + btl[i];
        nb  = 1 << (m_L[i] - 1);
        b   = (m_t[i] - 1) / p;
        ph  = (m_t[i] - 1) % p;
        lay = b / nb;
        bc  = b % nb;
        wr  = (ph == p - 1);
        return {ph == rdl[i] + 1, wr, wr, wr && (bc == nb - 1), lay == 0, lay == m_L[i] - 1,
                1'b1, 1'b0, LayWL'(lay), ButtWL'(bc)};
    endfunction

    always @(posedge CLK) begin
        edge_no++;
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                m_act[i] = 1'b0;
                m_t[i]   = 0;
            end else if (EN) begin
                if (!m_act[i]) begin
                    if (START) begin
                        m_act[i] = 1'b1;
                        m_t[i]   = 1;
`ifdef FFT_CTRL_RUNTIME_N_EN
                        m_L[i]   = clamp_n(int'(n_log2));
`else
                        m_L[i]   = clamp_n(LOG2N);
`endif
                        start_edge[i] = edge_no;
                    end
                end else if (m_t[i] == model_tdone(i)) begin
                    m_act[i] = 1'b0;
                    m_t[i]   = 0;
                end else begin
                    m_t[i]++;
                end
            end
        end
    end

    int n_wr, n_layen, n_strob, n_done_a, n_first, n_last;
    int first_min, first_max, last_min, last_max, done_cyc_a, done_cyc_b;

    task automatic clr_tally();
        n_wr = 0; n_layen = 0; n_strob = 0; n_done_a = 0; n_first = 0; n_last = 0;
        first_min = 9999; first_max = -1; last_min = 9999; last_max = -1;
        done_cyc_a = -1; done_cyc_b = -1;
    endtask

    always @(negedge CLK) begin
        if (edge_no > 0) begin
            logic [OW-1:0] e0, e1;
            int c;
            e0 = exp_out(0);
            e1 = exp_out(1);
            checks++;
            if (got_a !== e0) begin
                failures++;
                $display("FAIL cycle_a edge=%0d got=%b exp=%b", edge_no, got_a, e0);
            end
            checks++;
            if (got_b !== e1) begin
                failures++;
                $display("FAIL cycle_b edge=%0d got=%b exp=%b", edge_no, got_b, e1);
            end
            c = edge_no - start_edge[0] + 1;
            if (a_wr)    n_wr++;
            if (a_layen) n_layen++;
            if (a_strob) n_strob++;
            if (a_first) begin
                n_first++;
                if (c < first_min) first_min = c;
                if (c > first_max) first_max = c;
            end
            if (a_last) begin
                n_last++;
                if (c < last_min) last_min = c;
                if (c > last_max) last_max = c;
            end
            if (a_done) begin
                n_done_a++;
                done_cyc_a = c;
            end
            if (b_done) done_cyc_b = edge_no - start_edge[1] + 1;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((m_act[0] || m_act[1]) && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL %s_timeout got=%0d exp=<400", name, n);
        end
        step();
    endtask

    task automatic wait_t(input int t, input string name);
        int n = 0;
        while (m_t[0] != t && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL %s_reach got=%0d exp=%0d", name, m_t[0], t);
        end
    endtask

    initial begin
        RST = 1'b1; EN = 1'b1; START = 1'b0;
`ifdef FFT_CTRL_RUNTIME_N_EN
        n_log2 = 2'd3;
`endif
        clr_tally();
        repeat (3) step();
        chk("reset_a", int'(got_a), 0);
        chk("reset_b", int'(got_b), 0);
        RST = 1'b0;
        step();

        // Nominal run on both latency configurations.
        clr_tally();
        pulse_start();
        chk("model_tdone_a", model_tdone(0), 73);
        chk("model_tdone_b", model_tdone(1), 37);
        wait_idle("run1");
        chk("done_cyc_a", done_cyc_a, 73);
        chk("done_cyc_b", done_cyc_b, 37);
        chk("wr_count", n_wr, 12);
        chk("layen_count", n_layen, 3);
        chk("strob_count", n_strob, 12);
        chk("done_count", n_done_a, 1);
        chk("first_min", first_min, 1);
        chk("first_max", first_max, 24);
        chk("last_min", last_min, 49);
        chk("last_max", last_max, 72);
        chk("busy_after", int'(a_busy), 0);

        // Stall five cycles inside WAIT_BUT of butterfly 4.
        clr_tally();
        pulse_start();
        wait_t(22, "stall");
        EN = 1'b0;
        repeat (5) step();
        EN = 1'b1;
        wait_idle("run_stall");
        chk("stall_done_cyc", done_cyc_a, 78);
        chk("stall_wr_count", n_wr, 12);
        chk("stall_layen_count", n_layen, 3);

        // Reset mid-run with EN low: reset wins, no DONE, then a clean full run.
        clr_tally();
        pulse_start();
        wait_t(30, "rst");
        RST = 1'b1;
        EN  = 1'b0;
        step();
        RST = 1'b0;
        EN  = 1'b1;
        chk("abort_outputs", int'(got_a), 0);
        repeat (3) step();
        chk("abort_no_done", n_done_a, 0);
        clr_tally();
        pulse_start();
        wait_idle("run_after_rst");
        chk("rerun_done_cyc", done_cyc_a, 73);

        // START held across DONE restarts immediately after the IDLE cycle.
        clr_tally();
        START = 1'b1;
        repeat (80) step();
        START = 1'b0;
        wait_idle("run_held");
        chk("held_done_count", n_done_a, 2);

`ifdef FFT_CTRL_RUNTIME_N_EN
        clr_tally();
        n_log2 = 2'd2;
        pulse_start();
        n_log2 = 2'd3;
        wait_idle("run_n2");
        chk("n2_done_cyc", done_cyc_a, 25);
        chk("n2_done_cyc_b", done_cyc_b, 13);
        chk("n2_wr_count", n_wr, 4);
        clr_tally();
        n_log2 = 2'd0;
        pulse_start();
        wait_idle("run_n0");
        chk("n0_clamp_done_cyc", done_cyc_a, 73);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
